task_dispatch_selector: RTL and testbench
=========================================

# task_dispatch_selector

Consumes the per-sub-board status stream (free memory and pending-task count, one valid strobe per board) from the status detect stage. Keeps a freshness-tracked status table for 4 sub-boards. Answers one task-dispatch request at a time by picking the eligible board with the fewest pending tasks, breaking ties round-robin. After each grant it pre-charges the chosen board's table entry, so back-to-back requests do not pile onto one board before its next status report.

## Interface
- NUM_BOARDS, 4, number of sub-boards (fixed at 4 for this revision)
- MEM_W, 32, free-memory / request-size width
- TASK_W, 32, pending-task count width
- STALE_LIMIT, 1024, cycles without a status update after which a board is ineligible
- clk  in  1  the single clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid_id0..id3  in  1 each  status strobe for board N
- in_free_mem_id0..id3  in  MEM_W each  free memory of board N, sampled when its strobe is high
- in_pending_tasks_id0..id3  in  TASK_W each  pending tasks of board N, sampled when its strobe is high
- task_req_valid  in  1  dispatch request present
- task_req_mem  in  MEM_W  memory the task needs
- task_req_ready  out  1  high only in IDLE and not in reset
- grant_valid  out  1  grant result present; held until grant_ready
- grant_ready  in  1  consumer accepts the grant
- grant_ok  out  1  1 = a board was selected; 0 = no eligible board
- grant_board_id  out  2  selected board (0 when grant_ok=0)
- board_fresh  out  NUM_BOARDS  bit N high when board N is fresh

## Operation
- **Table, per board:** free_mem, pending, age.
  - Reset: free_mem=0, pending=0, age=STALE_LIMIT (stale).
  - in_valid_idN: load both fields, age←0.
  - Otherwise age increments, saturating at STALE_LIMIT.
  - Fresh iff age < STALE_LIMIT.
- **Eligible:** fresh AND free_mem ≥ task_req_mem. Comparisons are unsigned; the request size is latched at acceptance.
- **FSM IDLE→SCAN→GRANT→IDLE:**
  - IDLE: task_req_valid && task_req_ready accepts the request; latch task_req_mem, clear best, scan index←rr_ptr, go to SCAN.
  - SCAN: evaluate one board per cycle for NUM_BOARDS cycles, in order rr_ptr, rr_ptr+1, … (mod 4). An eligible board replaces best only if best is empty or its pending is strictly less, so ties go to the board earliest in round-robin order. After the 4th board, go to GRANT.
  - GRANT: grant_valid=1 with grant_ok/grant_board_id stable. On grant_ready, go to IDLE.
- **On grant handshake with grant_ok=1**, for selected board S:
  - pending[S] += 1, saturating at 2^TASK_W−1.
  - free_mem[S] −= latched request, saturating at 0.
  - rr_ptr ← S+1 mod 4.
  - With grant_ok=0, rr_ptr and the table are unchanged.
- **Simultaneous status strobe and pre-charge on the same board:** the strobe wins (fresh data overrides).
- **Status updates during SCAN** are written to the table. A board already evaluated in this scan is not re-evaluated.

## Timing
- **Reset** (rst high at an edge): state=IDLE, rr_ptr=0, grant_valid=0, grant_ok=0, grant_board_id=0, board_fresh=0, task_req_ready=0. task_req_ready rises in the first cycle after rst is sampled low.
- **Grant latency:** request accepted at edge T → grant_valid high after edge T+NUM_BOARDS+1. task_req_ready is low from T+1 until the cycle after the grant handshake.
- **board_fresh** is registered: it falls at the edge where age reaches STALE_LIMIT and rises one edge after the strobe.
- **Reset mid-SCAN/GRANT:** the request is dropped and no grant is emitted.
- grant_valid must not drop without grant_ready; outputs hold under backpressure indefinitely.

## Structure
- **Package status_pkg:** NUM_BOARDS, BOARD_ID_W=2, MEM_W, TASK_W, STALE_LIMIT default, and the FSM state enum (IDLE, SCAN, GRANT).
- **Sub-module board_status_entry**, instantiated once per board: fields, age counter, fresh flag, pre-charge port with strobe priority.
- The top level holds the FSM, the scan/compare datapath, and rr_ptr.

## Test plan
- Reset, then strobe boards 0..3 with pending=5,2,2,7 and free_mem=1000 each; request mem=100 → grant_ok=1, board 1 at T+5. Immediate second request → board 2 (pending tie 3 vs 2; board 1 now 3).
- Board 2 free_mem=50, others 1000; request mem=100 → board 2 never chosen; all boards free_mem<100 → grant_ok=0, grant_board_id=0, table unchanged.
- Strobe only board 3, then wait STALE_LIMIT cycles → board_fresh[3] falls; request → grant_ok=0. Re-strobe → board 3 granted.
- Hold grant_ready=0 for 20 cycles → grant_valid and grant fields stable, task_req_ready=0. Strobe the selected board in the handshake cycle → table shows strobed values, not pre-charged ones.
- Assert rst during SCAN → no grant; next cycle all outputs at reset values; board_fresh=0.
- Pending=2^32−1 on the chosen board → stays saturated after grant; request equal to free_mem → free_mem becomes 0.

Source files
------------

// File: rtl/task_dispatch_selector_pkg.sv
// Shared constants and FSM state type for the task dispatch selector slice.
package status_pkg;

    localparam int unsigned NUM_BOARDS      = 4;
    localparam int unsigned BOARD_ID_W      = 2;
    localparam int unsigned MEM_W           = 32;
    localparam int unsigned TASK_W          = 32;
    localparam int unsigned STALE_LIMIT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GRANT
    } state_t;

endpackage

// File: rtl/task_dispatch_selector_if.sv
// Request/grant handshake bundle between a task source and the dispatch selector.
interface task_dispatch_selector_if;
    import status_pkg::*;

    logic                  task_req_valid;
    logic [MEM_W-1:0]      task_req_mem;
    logic                  task_req_ready;
    logic                  grant_valid;
    logic                  grant_ready;
    logic                  grant_ok;
    logic [BOARD_ID_W-1:0] grant_board_id;

    modport master (
        output task_req_valid, task_req_mem, grant_ready,
        input  task_req_ready, grant_valid, grant_ok, grant_board_id
    );

    modport slave (
        input  task_req_valid, task_req_mem, grant_ready,
        output task_req_ready, grant_valid, grant_ok, grant_board_id
    );

endinterface

// File: rtl/task_dispatch_selector_board_status_entry.sv
// One sub-board status table entry: last reported free memory / pending tasks,
// staleness age, and a grant pre-charge that a same-cycle status strobe overrides.
module board_status_entry
    import status_pkg::*;
#(
    parameter int unsigned STALE_LIMIT = STALE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [MEM_W-1:0]  in_free_mem,
    input  logic [TASK_W-1:0] in_pending,
    input  logic              charge,
    input  logic [MEM_W-1:0]  charge_mem,
    output logic [MEM_W-1:0]  free_mem,
    output logic [TASK_W-1:0] pending,
    output logic              fresh
);

    localparam int unsigned AGE_W = $clog2(STALE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STALE_LIMIT);

    logic [AGE_W-1:0] age;
    logic [AGE_W-1:0] age_nxt;

    always_comb begin
        age_nxt = age;
        if (in_valid) begin
            age_nxt = '0;
        end else if (age != AGE_LIMIT) begin
            age_nxt = age + AGE_W'(1);
        end
    end

    // fresh is registered from the next age so it always equals (age < limit)
    always_ff @(posedge clk) begin
        if (rst) begin
            free_mem <= '0;
            pending  <= '0;
            age      <= AGE_LIMIT;
            fresh    <= 1'b0;
        end else begin
            age   <= age_nxt;
            fresh <= (age_nxt < AGE_LIMIT);
            if (in_valid) begin
                free_mem <= in_free_mem;
                pending  <= in_pending;
            end else if (charge) begin
                pending  <= (pending == '1) ? pending : pending + TASK_W'(1);
                free_mem <= (free_mem >= charge_mem) ? free_mem - charge_mem : '0;
            end
        end
    end

endmodule

// File: rtl/task_dispatch_selector.sv
// Picks the fresh sub-board with enough free memory and fewest pending tasks,
// scanning one board per cycle from a round-robin pointer so ties rotate.
module task_dispatch_selector
    import status_pkg::*;
#(
    parameter int unsigned STALE_LIMIT = STALE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_id0,
    input  logic                   in_valid_id1,
    input  logic                   in_valid_id2,
    input  logic                   in_valid_id3,
    input  logic [MEM_W-1:0]       in_free_mem_id0,
    input  logic [MEM_W-1:0]       in_free_mem_id1,
    input  logic [MEM_W-1:0]       in_free_mem_id2,
    input  logic [MEM_W-1:0]       in_free_mem_id3,
    input  logic [TASK_W-1:0]      in_pending_tasks_id0,
    input  logic [TASK_W-1:0]      in_pending_tasks_id1,
    input  logic [TASK_W-1:0]      in_pending_tasks_id2,
    input  logic [TASK_W-1:0]      in_pending_tasks_id3,
    task_dispatch_selector_if.slave disp,
    output logic [NUM_BOARDS-1:0]  board_fresh
);

    localparam int unsigned CNT_W = $clog2(NUM_BOARDS + 1);

    logic              st_valid     [NUM_BOARDS];
    logic [MEM_W-1:0]  st_mem       [NUM_BOARDS];
    logic [TASK_W-1:0] st_pend      [NUM_BOARDS];
    logic [MEM_W-1:0]  free_mem_tbl [NUM_BOARDS];
    logic [TASK_W-1:0] pend_tbl     [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] charge;

    state_t                state, state_nxt;
    logic [BOARD_ID_W-1:0] rr_ptr, scan_idx, best_id, grant_id_q;
    logic [CNT_W-1:0]      scan_cnt;
    logic                  best_valid, grant_ok_q, ready_q;
    logic [TASK_W-1:0]     best_pend;
    logic [MEM_W-1:0]      req_mem;
    logic                  accept, handshake, eligible, take;

    assign st_valid = '{in_valid_id0, in_valid_id1, in_valid_id2, in_valid_id3};
    assign st_mem   = '{in_free_mem_id0, in_free_mem_id1, in_free_mem_id2, in_free_mem_id3};
    assign st_pend  = '{in_pending_tasks_id0, in_pending_tasks_id1,
                        in_pending_tasks_id2, in_pending_tasks_id3};

    for (genvar i = 0; i < NUM_BOARDS; i++) begin : g_entry
        board_status_entry #(.STALE_LIMIT(STALE_LIMIT)) u_entry (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (st_valid[i]),
            .in_free_mem(st_mem[i]),
            .in_pending (st_pend[i]),
            .charge     (charge[i]),
            .charge_mem (req_mem),
            .free_mem   (free_mem_tbl[i]),
            .pending    (pend_tbl[i]),
            .fresh      (board_fresh[i])
        );
    end

    assign accept    = (state == IDLE) && disp.task_req_valid && ready_q;
    assign handshake = (state == GRANT) && disp.grant_ready;
    assign eligible  = board_fresh[scan_idx] && (free_mem_tbl[scan_idx] >= req_mem);
    assign take      = eligible && (!best_valid || (pend_tbl[scan_idx] < best_pend));

    assign disp.task_req_ready = ready_q;
    assign disp.grant_valid    = (state == GRANT);
    assign disp.grant_ok       = grant_ok_q;
    assign disp.grant_board_id = grant_id_q;

    always_comb begin
        charge = '0;
        if (handshake && grant_ok_q) begin
            charge[grant_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SCAN spends one extra cycle after the last board to register the result
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (scan_cnt == CNT_W'(NUM_BOARDS)) state_nxt = GRANT;
            GRANT:   if (disp.grant_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            scan_idx   <= '0;
            scan_cnt   <= '0;
            best_valid <= 1'b0;
            best_id    <= '0;
            best_pend  <= '0;
            req_mem    <= '0;
            grant_ok_q <= 1'b0;
            grant_id_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            case (state)
                IDLE: if (accept) begin
                    req_mem    <= disp.task_req_mem;
                    best_valid <= 1'b0;
                    scan_idx   <= rr_ptr;
                    scan_cnt   <= '0;
                end
                SCAN: if (scan_cnt != CNT_W'(NUM_BOARDS)) begin
                    if (take) begin
                        best_valid <= 1'b1;
                        best_id    <= scan_idx;
                        best_pend  <= pend_tbl[scan_idx];
                    end
                    scan_idx <= scan_idx + BOARD_ID_W'(1);
                    scan_cnt <= scan_cnt + CNT_W'(1);
                end else begin
                    grant_ok_q <= best_valid;
                    grant_id_q <= best_valid ? best_id : '0;
                end
                GRANT: if (disp.grant_ready && grant_ok_q) begin
                    rr_ptr <= grant_id_q + BOARD_ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_task_dispatch_selector.sv
// Directed self-checking bench for task_dispatch_selector.
module tb_task_dispatch_selector;
    import status_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic              sv [NUM_BOARDS];
    logic [MEM_W-1:0]  sm [NUM_BOARDS];
    logic [TASK_W-1:0] sp [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] board_fresh;
    int checks = 0;
    int errors = 0;

    task_dispatch_selector_if dif();

    task_dispatch_selector dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid_id0        (sv[0]),
        .in_valid_id1        (sv[1]),
        .in_valid_id2        (sv[2]),
        .in_valid_id3        (sv[3]),
        .in_free_mem_id0     (sm[0]),
        .in_free_mem_id1     (sm[1]),
        .in_free_mem_id2     (sm[2]),
        .in_free_mem_id3     (sm[3]),
        .in_pending_tasks_id0(sp[0]),
        .in_pending_tasks_id1(sp[1]),
        .in_pending_tasks_id2(sp[2]),
        .in_pending_tasks_id3(sp[3]),
        .disp                (dif),
        .board_fresh         (board_fresh)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input int b, input logic [MEM_W-1:0] m, input logic [TASK_W-1:0] p);
        sv[b] = 1'b1;
        sm[b] = m;
        sp[b] = p;
    endtask

    task automatic commit_status();
        tick();
        for (int i = 0; i < NUM_BOARDS; i++) sv[i] = 1'b0;
    endtask

    task automatic run_request(input logic [MEM_W-1:0] m, input string tag,
                               output logic ok, output logic [1:0] id);
        int n;
        checks++;
        if (dif.task_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", tag, dif.task_req_ready);
        end
        dif.task_req_valid = 1'b1;
        dif.task_req_mem   = m;
        tick();
        dif.task_req_valid = 1'b0;
        n = 0;
        while (dif.grant_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL %s latency: got %0d want 5", tag, n);
        end
        ok = dif.grant_ok;
        id = dif.grant_board_id;
    endtask

    task automatic handshake(input string tag);
        dif.grant_ready = 1'b1;
        tick();
        dif.grant_ready = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) sv[i] = 1'b0;
        checks++;
        if (dif.grant_valid !== 1'b0 || dif.task_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_hs: got valid=%b ready=%b want 0 1", tag,
                     dif.grant_valid, dif.task_req_ready);
        end
    endtask

    task automatic expect_grant(input string tag, input logic ok, input logic [1:0] id,
                                input logic wok, input logic [1:0] wid);
        checks++;
        if (ok !== wok || id !== wid) begin
            errors++;
            $display("FAIL %s grant: got ok=%b id=%0d want ok=%b id=%0d", tag, ok, id, wok, wid);
        end
    endtask

    task automatic expect_entry(input string tag, input int b,
                                input logic [MEM_W-1:0] wm, input logic [TASK_W-1:0] wp);
        checks++;
        if (dut.free_mem_tbl[b] !== wm || dut.pend_tbl[b] !== wp) begin
            errors++;
            $display("FAIL %s entry%0d: got mem=%0d pend=%0d want mem=%0d pend=%0d", tag, b,
                     dut.free_mem_tbl[b], dut.pend_tbl[b], wm, wp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (dif.task_req_ready !== 1'b0 || dif.grant_valid !== 1'b0 || dif.grant_ok !== 1'b0 ||
            dif.grant_board_id !== 2'd0 || board_fresh !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b gv=%b ok=%b id=%0d fresh=%b want all 0",
                     dif.task_req_ready, dif.grant_valid, dif.grant_ok, dif.grant_board_id, board_fresh);
        end
        rst = 1'b0;
        checks++;
        if (dif.task_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b want 0", dif.task_req_ready);
        end
        tick();
        checks++;
        if (dif.task_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b want 1", dif.task_req_ready);
        end
    endtask

    task automatic test_min_pending();
        logic ok;
        logic [1:0] id;
        set_status(0, 1000, 5);
        set_status(1, 1000, 2);
        set_status(2, 1000, 2);
        set_status(3, 1000, 7);
        commit_status();
        checks++;
        if (board_fresh !== 4'b1111) begin
            errors++;
            $display("FAIL fresh_after_strobe: got %b want 1111", board_fresh);
        end
        run_request(100, "minpend1", ok, id);
        expect_grant("minpend1", ok, id, 1'b1, 2'd1);
        handshake("minpend1");
        expect_entry("minpend1", 1, 900, 3);
        run_request(100, "minpend2", ok, id);
        expect_grant("minpend2", ok, id, 1'b1, 2'd2);
        handshake("minpend2");
        expect_entry("minpend2", 2, 900, 3);
    endtask

    task automatic test_mem_filter();
        logic ok;
        logic [1:0] id;
        // rr_ptr is 3 here; board 2 has the lowest pending but too little memory
        set_status(0, 1000, 5);
        set_status(1, 1000, 5);
        set_status(2, 50, 0);
        set_status(3, 1000, 5);
        commit_status();
        run_request(100, "memfilt", ok, id);
        expect_grant("memfilt", ok, id, 1'b1, 2'd3);
        handshake("memfilt");
        set_status(0, 10, 1);
        set_status(1, 20, 1);
        set_status(2, 30, 1);
        set_status(3, 99, 1);
        commit_status();
        run_request(100, "nofit", ok, id);
        expect_grant("nofit", ok, id, 1'b0, 2'd0);
        handshake("nofit");
        expect_entry("nofit", 0, 10, 1);
        expect_entry("nofit", 1, 20, 1);
        expect_entry("nofit", 2, 30, 1);
        expect_entry("nofit", 3, 99, 1);
    endtask

    task automatic test_stale();
        logic ok;
        logic [1:0] id;
        set_status(3, 1000, 4);
        commit_status();
        for (int i = 0; i < 1023; i++) tick();
        checks++;
        if (board_fresh[3] !== 1'b1) begin
            errors++;
            $display("FAIL stale_before: got %b want 1", board_fresh[3]);
        end
        tick();
        checks++;
        if (board_fresh !== 4'b0000) begin
            errors++;
            $display("FAIL stale_after: got %b want 0000", board_fresh);
        end
        run_request(100, "stale", ok, id);
        expect_grant("stale", ok, id, 1'b0, 2'd0);
        handshake("stale");
        set_status(3, 1000, 4);
        commit_status();
        checks++;
        if (board_fresh !== 4'b1000) begin
            errors++;
            $display("FAIL restrobe_fresh: got %b want 1000", board_fresh);
        end
        run_request(100, "restrobe", ok, id);
        expect_grant("restrobe", ok, id, 1'b1, 2'd3);
        handshake("restrobe");
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [1:0] id;
        int bad;
        set_status(0, 1000, 3);
        set_status(1, 1000, 1);
        set_status(2, 1000, 3);
        set_status(3, 1000, 3);
        commit_status();
        run_request(100, "bp", ok, id);
        expect_grant("bp", ok, id, 1'b1, 2'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dif.grant_valid !== 1'b1 || dif.grant_ok !== 1'b1 ||
                dif.grant_board_id !== 2'd1 || dif.task_req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        set_status(1, 777, 9);
        handshake("bp");
        expect_entry("bp_strobe_wins", 1, 777, 9);
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        dif.task_req_valid = 1'b1;
        dif.task_req_mem   = 10;
        tick();
        dif.task_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dif.task_req_ready !== 1'b0 || dif.grant_valid !== 1'b0 || dif.grant_ok !== 1'b0 ||
            dif.grant_board_id !== 2'd0 || board_fresh !== 4'b0000) begin
            errors++;
            $display("FAIL midscan_reset: got rdy=%b gv=%b ok=%b id=%0d fresh=%b want all 0",
                     dif.task_req_ready, dif.grant_valid, dif.grant_ok, dif.grant_board_id, board_fresh);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dif.grant_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midscan_nogrant: got %0d grant cycles want 0", seen);
        end
    endtask

    task automatic test_saturation();
        logic ok;
        logic [1:0] id;
        set_status(0, 500, 32'hFFFF_FFFF);
        commit_status();
        run_request(500, "sat", ok, id);
        expect_grant("sat", ok, id, 1'b1, 2'd0);
        handshake("sat");
        expect_entry("sat", 0, 0, 32'hFFFF_FFFF);
    endtask

    initial begin
        for (int i = 0; i < NUM_BOARDS; i++) begin
            sv[i] = 1'b0;
            sm[i] = '0;
            sp[i] = '0;
        end
        dif.task_req_valid = 1'b0;
        dif.task_req_mem   = '0;
        dif.grant_ready    = 1'b0;
        test_reset();
        test_min_pending();
        test_mem_filter();
        test_stale();
        test_backpressure();
        test_reset_mid_scan();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
